// File: rtl/cmp_pkg.sv
// Shared types and helpers for the serial compare sequencer.
package cmp_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..width inclusive.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cascadable_comparator.sv
// One-bit cascadable magnitude comparator stage.
// A higher-order decision (g or l already set) passes through untouched.
// A lower bit can only decide the result while the prefix is still equal.
module cascadable_comparator (
    input  logic a_bit,
    input  logic b_bit,
    input  logic g,
    input  logic e,
    input  logic l,
    output logic g_next,
    output logic e_next,
    output logic l_next
);

    // Combine the incoming cascade state with this bit pair.
    always_comb begin
        g_next = g | (e & a_bit & ~b_bit);
        e_next = e & (a_bit ~^ b_bit);
        l_next = l | (e & ~a_bit & b_bit);
    end

endmodule

// File: rtl/serial_compare_sequencer.sv
// Bit-serial magnitude comparator controller.
// Walks one cascadable_comparator stage across a WIDTH-bit operand pair,
// MSB first, one bit per clock, with optional early exit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new operand pair; in_ready high
// RUN   | stepping the stage over a_r/b_r, one bit per clock
// DONE  | result presented on g/e/l_out; held until out_ready
module serial_compare_sequencer
    import cmp_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  bit EARLY_EXIT = 1'b1,
    localparam int CW         = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             g_in,
    input  logic             e_in,
    input  logic             l_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             g_out,
    output logic             e_out,
    output logic             l_out,
    output logic             busy,
    output logic [CW-1:0]    cycles
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             g_r;
    logic             e_r;
    logic             l_r;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cycles_r;

    logic a_bit;
    logic b_bit;
    logic g_nx;
    logic e_nx;
    logic l_nx;
    logic accept;
    logic last;

    assign a_bit = a_r[idx];
    assign b_bit = b_r[idx];

    cascadable_comparator u_stage (
        .a_bit  (a_bit),
        .b_bit  (b_bit),
        .g      (g_r),
        .e      (e_r),
        .l      (l_r),
        .g_next (g_nx),
        .e_next (e_nx),
        .l_next (l_nx)
    );

    // Stop on the LSB, or as soon as the new result is decided when early exit is on.
    assign last = (idx == '0) || (EARLY_EXIT && (g_nx || l_nx));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, cascade state, bit index and cycle count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            g_r      <= 1'b0;
            e_r      <= 1'b0;
            l_r      <= 1'b0;
            idx      <= '0;
            cycles_r <= '0;
        end else if (accept) begin
            a_r      <= a;
            b_r      <= b;
            g_r      <= g_in;
            e_r      <= e_in;
            l_r      <= l_in;
            idx      <= IDX_MSB;
            cycles_r <= '0;
        end else if (state_q == RUN) begin
            g_r      <= g_nx;
            e_r      <= e_nx;
            l_r      <= l_nx;
            cycles_r <= cycles_r + CW'(1);
            if (!last) begin
                idx <= idx - IW'(1);
            end
        end
    end

    // Results are only exposed while a completed compare is being offered.
    assign g_out  = (state_q == DONE) & g_r;
    assign e_out  = (state_q == DONE) & e_r;
    assign l_out  = (state_q == DONE) & l_r;
    assign cycles = cycles_r;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Directed bench for serial_compare_sequencer (WIDTH=4), one instance with
// early exit and one without.
module tb_serial_compare_sequencer;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid, out_ready, g_in, e_in, l_in;
    logic [3:0] a, b;
    logic       in_ready, out_valid, g_out, e_out, l_out, busy;
    logic [2:0] cycles;

    logic       in_valid_x, out_ready_x, g_in_x, e_in_x, l_in_x;
    logic [3:0] a_x, b_x;
    logic       in_ready_x, out_valid_x, g_out_x, e_out_x, l_out_x, busy_x;
    logic [2:0] cycles_x;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_compare_sequencer #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .g_in(g_in), .e_in(e_in), .l_in(l_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .g_out(g_out), .e_out(e_out), .l_out(l_out),
        .busy(busy), .cycles(cycles)
    );

    serial_compare_sequencer #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut_x (
        .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready_x),
        .a(a_x), .b(b_x), .g_in(g_in_x), .e_in(e_in_x), .l_in(l_in_x),
        .out_valid(out_valid_x), .out_ready(out_ready_x),
        .g_out(g_out_x), .e_out(e_out_x), .l_out(l_out_x),
        .busy(busy_x), .cycles(cycles_x)
    );

    // Present one request on the early-exit instance; returns #1 after the accept edge.
    task automatic start_req(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] seed);
        @(negedge clk);
        a = av;
        b = bv;
        {g_in, e_in, l_in} = seed;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_hs: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
        end
        vectors++;
        if ({g_out, e_out, l_out, cycles} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_out: got gel=%b cycles=%0d want 000/0", {g_out, e_out, l_out}, cycles);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_early_exit();
        int lat;
        start_req(4'b1010, 4'b1001, 3'b010);
        wait_result(lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL ee_latency: got %0d want 3", lat);
        end
        vectors++;
        if ({out_valid, g_out, e_out, l_out} !== 4'b1100) begin
            miscompares++;
            $display("FAIL ee_result: got v,gel=%b want 1100", {out_valid, g_out, e_out, l_out});
        end
        vectors++;
        if (cycles !== 3'd3) begin
            miscompares++;
            $display("FAIL ee_cycles: got %0d want 3", cycles);
        end
        vectors++;
        if ({in_ready, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL ee_done_hs: got in_ready,busy=%b want 01", {in_ready, busy});
        end
        consume();
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL ee_consume: got out_valid,in_ready,busy=%b want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_no_early_exit();
        int lat;
        @(negedge clk);
        a_x = 4'b1010;
        b_x = 4'b1001;
        {g_in_x, e_in_x, l_in_x} = 3'b010;
        in_valid_x = 1'b1;
        @(posedge clk);
        #1;
        in_valid_x = 1'b0;
        lat = 0;
        while (!out_valid_x && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL noee_latency: got %0d want 4", lat);
        end
        vectors++;
        if ({out_valid_x, g_out_x, e_out_x, l_out_x, cycles_x} !== 7'b1100_100) begin
            miscompares++;
            $display("FAIL noee_result: got v,gel=%b cycles=%0d want 1100/4", {out_valid_x, g_out_x, e_out_x, l_out_x}, cycles_x);
        end
        @(negedge clk);
        out_ready_x = 1'b1;
        @(posedge clk);
        #1;
        out_ready_x = 1'b0;
        vectors++;
        if ({out_valid_x, in_ready_x} !== 2'b01) begin
            miscompares++;
            $display("FAIL noee_consume: got out_valid,in_ready=%b want 01", {out_valid_x, in_ready_x});
        end
    endtask

    task automatic test_equal_and_less();
        int lat;
        start_req(4'hC, 4'hC, 3'b010);
        wait_result(lat);
        vectors++;
        if (lat !== 4 || cycles !== 3'd4) begin
            miscompares++;
            $display("FAIL eq_len: got lat=%0d cycles=%0d want 4/4", lat, cycles);
        end
        vectors++;
        if ({out_valid, g_out, e_out, l_out} !== 4'b1010) begin
            miscompares++;
            $display("FAIL eq_result: got v,gel=%b want 1010", {out_valid, g_out, e_out, l_out});
        end
        consume();
        start_req(4'h3, 4'h8, 3'b010);
        wait_result(lat);
        vectors++;
        if (lat !== 1 || cycles !== 3'd1) begin
            miscompares++;
            $display("FAIL lt_len: got lat=%0d cycles=%0d want 1/1", lat, cycles);
        end
        vectors++;
        if ({out_valid, g_out, e_out, l_out} !== 4'b1001) begin
            miscompares++;
            $display("FAIL lt_result: got v,gel=%b want 1001", {out_valid, g_out, e_out, l_out});
        end
        consume();
    endtask

    task automatic test_seeds();
        int lat;
        start_req(4'h0, 4'hF, 3'b100);
        wait_result(lat);
        vectors++;
        if ({out_valid, g_out, e_out, l_out, cycles} !== 7'b1100_001) begin
            miscompares++;
            $display("FAIL seed_g: got v,gel=%b cycles=%0d want 1100/1", {out_valid, g_out, e_out, l_out}, cycles);
        end
        consume();
        start_req(4'h0, 4'hF, 3'b000);
        wait_result(lat);
        vectors++;
        if ({out_valid, g_out, e_out, l_out, cycles} !== 7'b1000_100) begin
            miscompares++;
            $display("FAIL seed_zero: got v,gel=%b cycles=%0d want 1000/4", {out_valid, g_out, e_out, l_out}, cycles);
        end
        consume();
        // g and e both set: MSB 0 vs 1 also sets l, g survives, e clears.
        start_req(4'h0, 4'hF, 3'b110);
        wait_result(lat);
        vectors++;
        if ({out_valid, g_out, e_out, l_out, cycles} !== 7'b1101_001) begin
            miscompares++;
            $display("FAIL seed_multi: got v,gel=%b cycles=%0d want 1101/1", {out_valid, g_out, e_out, l_out}, cycles);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        start_req(4'b1010, 4'b1001, 3'b010);
        wait_result(lat);
        @(negedge clk);
        a = 4'h3;
        b = 4'h8;
        {g_in, e_in, l_in} = 3'b010;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready, g_out, e_out, l_out, cycles} !== 8'b10_100_011) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v,rdy,gel=%b cycles=%0d want 10100/3", i, {out_valid, in_ready, g_out, e_out, l_out}, cycles);
            end
        end
        consume();
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_idle: got out_valid,in_ready,busy=%b want 010", {out_valid, in_ready, busy});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if ({in_ready, busy, cycles} !== 5'b01_000) begin
            miscompares++;
            $display("FAIL bp_accept: got in_ready,busy=%b cycles=%0d want 01/0", {in_ready, busy}, cycles);
        end
        wait_result(lat);
        vectors++;
        if ({out_valid, g_out, e_out, l_out, cycles} !== 7'b1001_001 || lat !== 1) begin
            miscompares++;
            $display("FAIL bp_next: got v,gel=%b cycles=%0d lat=%0d want 1001/1/1", {out_valid, g_out, e_out, l_out}, cycles, lat);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_req(4'h5, 4'h5, 3'b010);
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, cycles} !== 4'b1_001) begin
            miscompares++;
            $display("FAIL rr_pre: got busy=%b cycles=%0d want 1/1", busy, cycles);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, g_out, e_out, l_out, busy, in_ready, cycles} !== 9'b0000_01_000) begin
            miscompares++;
            $display("FAIL rr_async: got v,gel,busy,rdy=%b cycles=%0d want 000001/0", {out_valid, g_out, e_out, l_out, busy, in_ready}, cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        start_req(4'h3, 4'h8, 3'b010);
        wait_result(lat);
        vectors++;
        if ({out_valid, g_out, e_out, l_out, cycles} !== 7'b1001_001 || lat !== 1) begin
            miscompares++;
            $display("FAIL rr_after: got v,gel=%b cycles=%0d lat=%0d want 1001/1/1", {out_valid, g_out, e_out, l_out}, cycles, lat);
        end
        consume();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        {g_in, e_in, l_in} = 3'b000;
        in_valid_x = 1'b0;
        out_ready_x = 1'b0;
        a_x = '0;
        b_x = '0;
        {g_in_x, e_in_x, l_in_x} = 3'b000;
        test_reset();
        test_early_exit();
        test_no_early_exit();
        test_equal_and_less();
        test_seeds();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
